// File: rtl/dqs_eye_trainer.sv
// DQS eye trainer: walks a delay line toward the centre of the data eye using early/late monitor flags.
// Optional build macro DQS_TRAIN_TRACK_EN keeps adjusting the delay line after lock.
module dqs_eye_trainer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MAX_TAPS      = 127,
  parameter int LOCK_WINDOWS  = 4,
  parameter int MAX_STEPS     = 255
) (
  input  logic       FAB_CLK,
  input  logic       SYNC_RST,
  input  logic       START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic [7:0] TAP_POS,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOCK_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int STEP_W  = $clog2(MAX_STEPS + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, STEP, LOCKED, FAILED
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [LOCK_W-1:0] lock_reg, lock_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [7:0]        tap_reg, tap_next;
  logic              dir_reg, dir_next;
  logic              early_reg, early_next;
  logic              late_reg, late_next;
  logic              done_reg, done_next;

  logic running;
  logic busy;
  logic start_ok;
  logic budget_spent;

  assign running      = state_reg inside {LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, STEP};
  // While tracking after lock the FSM cycles through window states but reports itself as not busy.
  assign busy         = running && !done_reg;
  assign start_ok     = START && !busy;
  assign budget_spent = (step_reg == STEP_W'(MAX_STEPS));

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      lock_reg  <= '0;
      step_reg  <= '0;
      tap_reg   <= '0;
      dir_reg   <= 1'b0;
      early_reg <= 1'b0;
      late_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lock_reg  <= lock_next;
      step_reg  <= step_next;
      tap_reg   <= tap_next;
      dir_reg   <= dir_next;
      early_reg <= early_next;
      late_reg  <= late_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_next  = lock_reg;
    step_next  = step_reg;
    tap_next   = tap_reg;
    dir_next   = dir_reg;
    early_next = early_reg;
    late_next  = late_reg;
    done_next  = done_reg;

    if (start_ok) begin
      state_next = LOAD;
      cnt_next   = '0;
      lock_next  = '0;
      step_next  = '0;
      tap_next   = '0;
      done_next  = 1'b0;
    end else if (running && DELAY_LINE_OUT_OF_RANGE) begin
      state_next = FAILED;
    end else begin
      case (state_reg)
        LOAD: state_next = CLEAR;
        CLEAR: begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
        SETTLE: begin
          if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_next = SAMPLE;
            cnt_next   = '0;
            early_next = 1'b0;
            late_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        SAMPLE: begin
          early_next = early_reg | EYE_MONITOR_EARLY;
          late_next  = late_reg | EYE_MONITOR_LATE;
          if (cnt_reg == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_next = DECIDE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DECIDE: begin
          case ({early_reg, late_reg})
            2'b10: begin
              lock_next = '0;
              if (tap_reg >= 8'(MAX_TAPS) || budget_spent) begin
                state_next = FAILED;
              end else begin
                dir_next   = 1'b1;
                state_next = STEP;
              end
            end
            2'b01: begin
              lock_next = '0;
              if (tap_reg == 8'd0 || budget_spent) begin
                state_next = FAILED;
              end else begin
                dir_next   = 1'b0;
                state_next = STEP;
              end
            end
            2'b00: begin
              // Saturates so post-lock tracking windows keep re-declaring lock.
              if (int'(lock_reg) + 1 >= LOCK_WINDOWS) begin
                lock_next  = LOCK_W'(LOCK_WINDOWS);
                done_next  = 1'b1;
                state_next = LOCKED;
              end else begin
                lock_next  = lock_reg + LOCK_W'(1);
                state_next = CLEAR;
              end
            end
            default: begin
              lock_next  = '0;
              state_next = CLEAR;
            end
          endcase
        end
        STEP: begin
          tap_next   = dir_reg ? tap_reg + 8'd1 : tap_reg - 8'd1;
          step_next  = step_reg + STEP_W'(1);
          state_next = CLEAR;
        end
        LOCKED: begin
`ifdef DQS_TRAIN_TRACK_EN
          state_next = CLEAR;
`else
          state_next = LOCKED;
`endif
        end
        default: state_next = state_reg;
      endcase
    end

    // DONE and FAIL are mutually exclusive.
    if (state_next == FAILED) begin
      done_next = 1'b0;
    end
  end

  assign DELAY_LINE_LOAD         = (state_reg == LOAD);
  assign DELAY_LINE_MOVE         = (state_reg == STEP);
  assign DELAY_LINE_DIRECTION    = dir_reg;
  assign EYE_MONITOR_CLEAR_FLAGS = (state_reg == CLEAR);
  assign TAP_POS                 = tap_reg;
  assign BUSY                    = busy;
  assign DONE                    = done_reg;
  assign FAIL                    = (state_reg == FAILED);

endmodule

// File: tb/tb_dqs_eye_trainer.sv
// Bench for dqs_eye_trainer: window-level scenarios compared with a per-window reference model.
module tb_dqs_eye_trainer;

  localparam int SETTLE  = 16;
  localparam int SAMPLE  = 64;
  localparam int MAXT    = 7;
  localparam int LOCKW   = 4;
  localparam int MAXS    = 12;
  localparam int WIN_CYC = SETTLE + SAMPLE + 2;
  localparam int RUN_TIMEOUT = 4000;

  logic       FAB_CLK = 1'b0;
  logic       SYNC_RST, START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic [7:0] TAP_POS;
  logic       BUSY, DONE, FAIL;
  logic [13:0] out_vec;

  dqs_eye_trainer #(
    .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE), .MAX_TAPS(MAXT),
    .LOCK_WINDOWS(LOCKW), .MAX_STEPS(MAXS)
  ) dut (
    .FAB_CLK(FAB_CLK), .SYNC_RST(SYNC_RST), .START(START),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .TAP_POS(TAP_POS), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  assign out_vec = {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
                    TAP_POS, BUSY, DONE, FAIL};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observed results of one training run.
  int          r_done, r_fail, r_tap, r_moves, r_wins, r_cyc, r_loads, r_viol, r_timeout;
  logic [31:0] r_dirs;

  // Reference model: one iteration per observation window.
  task automatic model(input logic [31:0] em, input logic [31:0] lm,
                       output int done, output int fail, output int tap,
                       output int moves, output int wins, output logic [31:0] dirs);
    int steps, lock;
    logic e, l;
    done = 0; fail = 0; tap = 0; moves = 0; wins = 0; dirs = '0;
    steps = 0; lock = 0;
    for (int w = 0; w < 64 && done == 0 && fail == 0; w++) begin
      e = (w < 32) ? em[w[4:0]] : 1'b0;
      l = (w < 32) ? lm[w[4:0]] : 1'b0;
      wins++;
      if (e && !l) begin
        lock = 0;
        if (tap == MAXT || steps == MAXS) fail = 1;
        else begin dirs[moves[4:0]] = 1'b1; moves++; tap++; steps++; end
      end else if (!e && l) begin
        lock = 0;
        if (tap == 0 || steps == MAXS) fail = 1;
        else begin dirs[moves[4:0]] = 1'b0; moves++; tap--; steps++; end
      end else if (!e && !l) begin
        lock++;
        if (lock == LOCKW) done = 1;
      end else begin
        lock = 0;
      end
    end
  endtask

  task automatic do_reset();
    SYNC_RST = 1'b1;
    START = 1'b0;
    EYE_MONITOR_EARLY = 1'b0;
    EYE_MONITOR_LATE = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
  endtask

  // Starts a run (called at a negedge) and drives the flags for each window as its clear pulse appears.
  task automatic run(input logic [31:0] em, input logic [31:0] lm, input int mid_start);
    int cyc, widx, finished;
    r_moves = 0; r_wins = 0; r_loads = 0; r_viol = 0; r_dirs = '0;
    widx = 0; finished = 0; cyc = 0;
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    while (finished == 0 && cyc < RUN_TIMEOUT) begin
      cyc++;
      if (DELAY_LINE_LOAD) r_loads++;
      if (int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS) > 1) r_viol++;
      if (DONE && FAIL) r_viol++;
      if (DELAY_LINE_MOVE) begin
        if (r_moves < 32) r_dirs[r_moves[4:0]] = DELAY_LINE_DIRECTION;
        r_moves++;
      end
      if (EYE_MONITOR_CLEAR_FLAGS) begin
        EYE_MONITOR_EARLY = (widx < 32) ? em[widx[4:0]] : 1'b0;
        EYE_MONITOR_LATE  = (widx < 32) ? lm[widx[4:0]] : 1'b0;
        widx++;
        r_wins++;
      end
      START = (cyc == mid_start);
      if (DONE || FAIL) finished = 1;
      else @(negedge FAB_CLK);
    end
    r_cyc = cyc; r_done = int'(DONE); r_fail = int'(FAIL); r_tap = int'(TAP_POS);
    r_timeout = (finished == 0);
    START = 1'b0;
    EYE_MONITOR_EARLY = 1'b0;
    EYE_MONITOR_LATE = 1'b0;
  endtask

  task automatic check_run(input string tag, input int done, input int fail, input int tap,
                           input int moves, input int wins, input logic [31:0] dirs);
    logic [31:0] mask;
    mask = (moves >= 32) ? 32'hFFFF_FFFF : ((32'd1 << moves) - 32'd1);
    check({tag, " timeout"}, r_timeout, 0);
    check({tag, " done"}, r_done, done);
    check({tag, " fail"}, r_fail, fail);
    check({tag, " tap"}, r_tap, tap);
    check({tag, " moves"}, r_moves, moves);
    check({tag, " windows"}, r_wins, wins);
    check({tag, " cycles"}, r_cyc, 2 + WIN_CYC * wins + moves);
    check({tag, " loads"}, r_loads, 1);
    check({tag, " pulse_excl"}, r_viol, 0);
    check({tag, " dirs"}, int'(r_dirs & mask), int'(dirs & mask));
  endtask

  typedef struct {
    logic [31:0] em;
    logic [31:0] lm;
    int          mid_start;
    int          done;
    int          fail;
    int          tap;
    int          moves;
    int          wins;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_done, m_fail, m_tap, m_moves, m_wins, cnt, seen;
    logic [31:0] m_dirs, em, lm;

    //            early mask      late mask       midS done fail tap mv wins
    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 100, 1, 0, 0, 0, 4};
    tbl[1] = '{32'h0000_0007, 32'h0000_0000,   0, 1, 0, 3, 3, 7};
    tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF,   0, 0, 1, 0, 0, 1};
    tbl[3] = '{32'h0000_007F, 32'h0000_0000,   0, 1, 0, 7, 7, 11};
    tbl[4] = '{32'h0000_00FF, 32'h0000_0000,   0, 0, 1, 7, 7, 8};
    tbl[5] = '{32'h0000_1555, 32'h0000_0AAA,   0, 0, 1, 0, 12, 13};
    tbl[6] = '{32'h0000_0007, 32'h0000_0007,   0, 1, 0, 0, 0, 7};
    tbl[7] = '{32'h0000_0008, 32'h0000_0000,   0, 1, 0, 1, 1, 8};
    tbl[8] = '{32'h0000_0003, 32'h0000_0004,   0, 1, 0, 1, 3, 7};

    // Reset wins over a simultaneous START.
    SYNC_RST = 1'b1; START = 1'b1;
    EYE_MONITOR_EARLY = 1'b0; EYE_MONITOR_LATE = 1'b0; DELAY_LINE_OUT_OF_RANGE = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    check("reset_outputs", int'(out_vec), 0);
    SYNC_RST = 1'b0; START = 1'b0;
    @(negedge FAB_CLK);
    check("idle_after_reset", int'(out_vec), 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      model(tbl[i].em, tbl[i].lm, m_done, m_fail, m_tap, m_moves, m_wins, m_dirs);
      run(tbl[i].em, tbl[i].lm, tbl[i].mid_start);
      check_run($sformatf("vec%0d", i), tbl[i].done, tbl[i].fail, tbl[i].tap,
                tbl[i].moves, tbl[i].wins, m_dirs);
      $display("vec%0d: done=%0d fail=%0d tap=%0d moves=%0d windows=%0d cycles=%0d",
               i, r_done, r_fail, r_tap, r_moves, r_wins, r_cyc);
    end

    // Behaviour after lock.
    do_reset();
    run(32'h7, 32'h0, 0);
    check("postlock start tap", r_tap, 3);
    EYE_MONITOR_LATE = 1'b1;
`ifdef DQS_TRAIN_TRACK_EN
    cnt = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_MOVE) begin
        cnt++;
        check("track move dir", int'(DELAY_LINE_DIRECTION), 0);
        EYE_MONITOR_LATE = 1'b0;
      end
      if (!DONE) seen++;
    end
    check("track moves", cnt, 1);
    check("track tap", int'(TAP_POS), 2);
    check("track done_dropped", seen, 0);
    $display("postlock tracking: moves=%0d tap=%0d done=%0d", cnt, TAP_POS, DONE);
`else
    cnt = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD || DELAY_LINE_MOVE || EYE_MONITOR_CLEAR_FLAGS) cnt++;
      if (!DONE || BUSY) seen++;
    end
    check("locked pulses", cnt, 0);
    check("locked done_held", seen, 0);
    check("locked tap", int'(TAP_POS), 3);
    $display("postlock terminal: pulses=%0d tap=%0d done=%0d", cnt, TAP_POS, DONE);
`endif
    EYE_MONITOR_LATE = 1'b0;

    // Out-of-range flag during SAMPLE (cycle 40 after START) aborts next cycle.
    do_reset();
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    repeat (39) @(negedge FAB_CLK);
    check("oor busy_before", int'(BUSY), 1);
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    check("oor fail", int'(FAIL), 1);
    check("oor busy", int'(BUSY), 0);
    check("oor done", int'(DONE), 0);
    $display("oor abort: fail=%0d busy=%0d", FAIL, BUSY);

    // Reset during STEP, then a clean run.
    do_reset();
    EYE_MONITOR_EARLY = 1'b1;
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    seen = 0;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      if (DELAY_LINE_MOVE) seen = 1;
      else @(negedge FAB_CLK);
    end
    check("step_reset move_seen", seen, 1);
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK);
    check("step_reset outputs", int'(out_vec), 0);
    SYNC_RST = 1'b0;
    EYE_MONITOR_EARLY = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge FAB_CLK);
      if (out_vec != 14'd0) cnt++;
    end
    check("step_reset quiet", cnt, 0);
    model(32'h0, 32'h0, m_done, m_fail, m_tap, m_moves, m_wins, m_dirs);
    run(32'h0, 32'h0, 0);
    check_run("after_reset", m_done, m_fail, m_tap, m_moves, m_wins, m_dirs);
    $display("reset in step: recovered run done=%0d tap=%0d cycles=%0d", r_done, r_tap, r_cyc);

    // Randomized window scenarios against the model.
    for (int i = 0; i < 12; i++) begin
      em = $urandom & $urandom & $urandom & 32'h0000_FFFF;
      lm = $urandom & $urandom & $urandom & 32'h0000_FFFF;
      do_reset();
      model(em, lm, m_done, m_fail, m_tap, m_moves, m_wins, m_dirs);
      run(em, lm, 0);
      check_run($sformatf("rnd%0d", i), m_done, m_fail, m_tap, m_moves, m_wins, m_dirs);
      $display("rnd%0d: em=%h lm=%h done=%0d fail=%0d tap=%0d moves=%0d windows=%0d",
               i, em, lm, r_done, r_fail, r_tap, r_moves, r_wins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dqs_eye_trainer.md
DQS_EYE_TRAINER -- requirements
Module: dqs_eye_trainer

Interface
REQ-001 The block SHALL have a parameter SETTLE_CYCLES, default 16, giving the wait in FAB_CLK cycles after any delay-line change or flag clear.
REQ-002 The block SHALL have a parameter SAMPLE_CYCLES, default 64, giving the eye-monitor observation window length in cycles.
REQ-003 The block SHALL have a parameter MAX_TAPS, default 127, giving the highest legal tap position.
REQ-004 The block SHALL have a parameter LOCK_WINDOWS, default 4, giving the number of consecutive clean windows required to declare lock.
REQ-005 The block SHALL have a parameter MAX_STEPS, default 255, giving the delay-line step budget per training run.
REQ-006 The block SHALL have a single clock FAB_CLK and a single synchronous, active-high reset SYNC_RST; all state SHALL change only on the rising edge of FAB_CLK.
REQ-007 The block SHALL have these ports, one per line (name  direction  width  meaning):
- FAB_CLK  in  1  fabric clock
- SYNC_RST  in  1  synchronous active-high reset
- START  in  1  single-cycle pulse requesting a training run
- EYE_MONITOR_EARLY  in  1  lane early flag
- EYE_MONITOR_LATE  in  1  lane late flag
- DELAY_LINE_OUT_OF_RANGE  in  1  delay-line limit flag
- DELAY_LINE_LOAD  out  1  one-cycle pulse that reloads the static delay
- DELAY_LINE_MOVE  out  1  one-cycle step pulse
- DELAY_LINE_DIRECTION  out  1  step direction: 1 = increment, 0 = decrement
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle flag-clear pulse
- TAP_POS  out  8  current tap offset
- BUSY  out  1  training in progress
- DONE  out  1  lock achieved
- FAIL  out  1  training aborted

Function
REQ-008 The state machine SHALL have the states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, STEP, LOCKED and FAILED.
REQ-009 In IDLE, LOCKED or FAILED, START=1 SHALL move the FSM to LOAD, clear DONE, FAIL, TAP_POS, the step count and the lock count, and set BUSY the next cycle.
REQ-010 LOAD SHALL assert DELAY_LINE_LOAD for exactly one cycle and then go to CLEAR.
REQ-011 CLEAR SHALL assert EYE_MONITOR_CLEAR_FLAGS for exactly one cycle and then go to SETTLE.
REQ-012 SETTLE SHALL last SETTLE_CYCLES cycles and then go to SAMPLE.
REQ-013 SAMPLE SHALL last SAMPLE_CYCLES cycles, sticky-OR EYE_MONITOR_EARLY into E and EYE_MONITOR_LATE into L, and then go to DECIDE; E and L SHALL clear on entry to SAMPLE.
REQ-014 DECIDE SHALL take one cycle and act as follows:
- E=1, L=0: step with direction 1, lock count cleared.
- E=0, L=1: step with direction 0, lock count cleared.
- E=0, L=0: lock count +1; go to LOCKED when it reaches LOCK_WINDOWS, otherwise go to CLEAR.
- E=1, L=1: lock count cleared, go to CLEAR.
REQ-015 Before stepping, DECIDE SHALL go to FAILED if the step would take TAP_POS above MAX_TAPS or below 0, or if the step count equals MAX_STEPS.
REQ-016 STEP SHALL assert DELAY_LINE_MOVE for one cycle with DELAY_LINE_DIRECTION valid in the same cycle, update TAP_POS and the step count in that cycle, and then go to CLEAR.
REQ-017 DELAY_LINE_OUT_OF_RANGE=1 sampled in any BUSY state SHALL move the FSM to FAILED on the next cycle.
REQ-018 In LOCKED, DONE SHALL be 1 and BUSY 0; in FAILED, FAIL SHALL be 1 and BUSY 0; DONE and FAIL SHALL never both be 1.
REQ-019 START asserted while BUSY SHALL be ignored.
REQ-020 At most one of DELAY_LINE_LOAD, DELAY_LINE_MOVE and EYE_MONITOR_CLEAR_FLAGS SHALL be high in any cycle.

Reset
REQ-021 SYNC_RST=1 SHALL force IDLE, set every output and counter to 0, and override START in the same cycle.
REQ-022 Reset asserted mid-run SHALL abort the run with no further delay-line pulses issued.

Configuration
REQ-023 With DQS_TRAIN_TRACK_EN defined, LOCKED SHALL re-enter CLEAR on its own and keep running windows, steps and out-of-range checks with DONE held at 1; DONE SHALL drop only on a transition to FAILED or on START.
REQ-024 Without DQS_TRAIN_TRACK_EN, LOCKED SHALL be terminal until START or SYNC_RST, with no delay-line or clear pulses issued.

Verification
REQ-025 Eye monitor quiet, START pulse -> LOAD pulse, then 4 clean windows, DONE=1 and TAP_POS=0 after 4×(1+16+64+1)+2 cycles.
REQ-026 EARLY held high for the first 3 windows, then quiet -> 3 MOVE pulses with DIRECTION=1, TAP_POS=3, DONE=1.
REQ-027 LATE held high from TAP_POS=0 -> no MOVE pulse, FAIL=1, TAP_POS=0.
REQ-028 DELAY_LINE_OUT_OF_RANGE pulsed during SAMPLE -> FAIL=1 next cycle, BUSY=0.
REQ-029 SYNC_RST asserted during STEP -> next cycle all outputs 0, FSM in IDLE; a following START runs normally.
REQ-030 With DQS_TRAIN_TRACK_EN, LATE injected after DONE -> one MOVE with DIRECTION=0, TAP_POS decrements by 1, DONE stays 1.
